// File: rtl/wbu_stage.sv
// Write-back stage: one-entry slot between EXU/MEM and the register file / commit port.
// Formats load data, selects the write-back source, counts retirements and flags illegal selects.
module wbu_stage #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 64,
  parameter int HAS_CSR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  exu_result_i,
  input  logic [XLEN-1:0]  mem_data_i,
  input  logic [XLEN-1:0]  csr_data_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [RA_W-1:0]  rd_i,
  input  logic [1:0]       regS,
  input  logic [2:0]       ld_funct3_i,
  input  logic             RegW,
  output logic             cm_valid_o,
  input  logic             cm_ready_i,
  output logic [XLEN-1:0]  cm_pc_o,
  output logic [XLEN-1:0]  reg_write_data_o,
  output logic [RA_W-1:0]  reg_write_addr_o,
  output logic             reg_write_en_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             err_o
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic             vld;
  logic [XLEN-1:0]  slot_data;
  logic [XLEN-1:0]  slot_pc;
  logic [RA_W-1:0]  slot_rd;
  logic             slot_regw;
  logic [CNT_W-1:0] retire_cnt;
  logic             err;

  logic             accept;
  logic             commit;

  logic [OFF_W-1:0] ld_off;
  logic [XLEN-1:0]  ld_shift;
  logic [XLEN-1:0]  ld_mask;
  logic [XLEN-1:0]  ld_data;
  logic             ld_sbit;
  logic             ld_bad;

  logic [XLEN-1:0]  sel_data;
  logic             sel_regw;
  logic             sel_err;

  assign in_ready_o = !vld || cm_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign commit     = vld && cm_ready_i;

  // Field is isolated with a mask; sign extension fills everything above the mask.
  always_comb begin
    ld_off   = exu_result_i[OFF_W-1:0];
    ld_shift = mem_data_i >> {ld_off, 3'b000};
    ld_bad   = (ld_funct3_i == 3'b111) ||
               ((XLEN == 32) && ((ld_funct3_i == 3'b011) || (ld_funct3_i == 3'b110)));
    ld_mask  = '1;
    ld_sbit  = ld_shift[XLEN-1];
    case (ld_funct3_i[1:0])
      2'b00: begin
        ld_mask = XLEN'(64'h0000_0000_0000_00FF);
        ld_sbit = ld_shift[7];
      end
      2'b01: begin
        ld_mask = XLEN'(64'h0000_0000_0000_FFFF);
        ld_sbit = ld_shift[15];
      end
      2'b10: begin
        ld_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
        ld_sbit = ld_shift[31];
      end
      default: begin
        ld_mask = '1;
        ld_sbit = ld_shift[XLEN-1];
      end
    endcase
    ld_data = ld_shift & ld_mask;
    if (!ld_funct3_i[2] && ld_sbit) begin
      ld_data = ld_data | ~ld_mask;
    end
    if (ld_bad) begin
      ld_data = '0;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_regw = RegW;
    sel_err  = 1'b0;
    case (regS)
      2'd0: sel_data = exu_result_i;
      2'd1: begin
        sel_data = ld_data;
        sel_err  = ld_bad;
      end
      2'd2: sel_data = pc_i + XLEN'(4);
      default: begin
        if (HAS_CSR != 0) begin
          sel_data = csr_data_i;
        end else begin
          sel_data = '0;
          sel_regw = 1'b0;
          sel_err  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= 1'b0;
      slot_data  <= '0;
      slot_pc    <= '0;
      slot_rd    <= '0;
      slot_regw  <= 1'b0;
      retire_cnt <= '0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        vld       <= 1'b1;
        slot_data <= sel_data;
        slot_pc   <= pc_i;
        slot_rd   <= rd_i;
        slot_regw <= sel_regw;
      end else if (commit) begin
        vld <= 1'b0;
      end
      if (commit) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (accept && sel_err) begin
        err <= 1'b1;
      end
    end
  end

  // Gated by rst so an entry discarded by reset is never seen as committed.
  assign cm_valid_o       = vld && !rst;
  assign reg_write_en_o   = commit && slot_regw && (slot_rd != '0) && !rst;
  assign reg_write_data_o = slot_data;
  assign reg_write_addr_o = slot_rd;
  assign cm_pc_o          = slot_pc;
  assign retire_cnt_o     = retire_cnt;
  assign err_o            = err;

endmodule

// File: tb/tb_wbu_stage.sv
// Bench for wbu_stage: one instance with CSR source and one without, sharing all inputs,
// checked against a queue-based model of the write-back slot.
module tb_wbu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] exu, mem, csr, pc;
  logic [4:0]  rd;
  logic [1:0]  regs;
  logic [2:0]  f3;
  logic        regw;
  logic        cm_ready;

  logic        in_ready1, cm_valid1, wen1, err1;
  logic [31:0] cm_pc1, data1;
  logic [4:0]  addr1;
  logic [63:0] cnt1;
  logic        in_ready0, cm_valid0, wen0, err0;
  logic [31:0] cm_pc0, data0;
  logic [4:0]  addr0;
  logic [63:0] cnt0;

  always #5 clk = ~clk;

  wbu_stage #(.XLEN(32), .RA_W(5), .CNT_W(64), .HAS_CSR(1)) u_csr (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .exu_result_i(exu), .mem_data_i(mem), .csr_data_i(csr), .pc_i(pc), .rd_i(rd),
    .regS(regs), .ld_funct3_i(f3), .RegW(regw), .cm_valid_o(cm_valid1),
    .cm_ready_i(cm_ready), .cm_pc_o(cm_pc1), .reg_write_data_o(data1),
    .reg_write_addr_o(addr1), .reg_write_en_o(wen1), .retire_cnt_o(cnt1), .err_o(err1)
  );

  wbu_stage #(.XLEN(32), .RA_W(5), .CNT_W(64), .HAS_CSR(0)) u_nocsr (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .exu_result_i(exu), .mem_data_i(mem), .csr_data_i(csr), .pc_i(pc), .rd_i(rd),
    .regS(regs), .ld_funct3_i(f3), .RegW(regw), .cm_valid_o(cm_valid0),
    .cm_ready_i(cm_ready), .cm_pc_o(cm_pc0), .reg_write_data_o(data0),
    .reg_write_addr_o(addr0), .reg_write_en_o(wen0), .retire_cnt_o(cnt0), .err_o(err0)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          wen;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  longint unsigned exp_cnt;
  bit exp_err1, exp_err0;
  int n_pass = 0;
  int n_total = 0;

  // Reference: write-back value from plain arithmetic on the current inputs.
  function automatic ent_t mk_ent(input bit has_csr, output bit err);
    ent_t e;
    longint unsigned v;
    int bits;
    bit wr;
    err = 1'b0;
    wr  = regw;
    v   = 0;
    case (regs)
      2'd0: v = exu;
      2'd1: begin
        if (f3 == 3'd7 || f3 == 3'd3 || f3 == 3'd6) begin
          err = 1'b1;
          v   = 0;
        end else begin
          bits = 8 * (1 << f3[1:0]);
          v = longint'(mem) / (64'd1 << (8 * (exu % 4)));
          v = v % (64'd1 << bits);
          if (!f3[2] && v >= (64'd1 << (bits - 1)))
            v = (v + (64'd1 << 32) - (64'd1 << bits)) % (64'd1 << 32);
        end
      end
      2'd2: v = (longint'(pc) + 4) % (64'd1 << 32);
      default: begin
        if (has_csr) v = csr;
        else begin
          v   = 0;
          err = 1'b1;
          wr  = 1'b0;
        end
      end
    endcase
    e.data = v[31:0];
    e.pc   = pc;
    e.rd   = rd;
    e.wen  = wr && (rd != 0);
    return e;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then move to the next negedge.
  task automatic tick();
    bit acc, cmt, e1, e0;
    ent_t n1, n0;
    cmt = (q1.size() != 0) && cm_ready;
    acc = in_valid && ((q1.size() == 0) || cm_ready);
    n1 = mk_ent(1'b1, e1);
    n0 = mk_ent(1'b0, e0);
    if (rst) begin
      q1.delete();
      q0.delete();
      exp_cnt  = 0;
      exp_err1 = 0;
      exp_err0 = 0;
    end else begin
      if (cmt) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
        exp_cnt++;
      end
      if (acc) begin
        q1.push_back(n1);
        q0.push_back(n0);
        if (e1) exp_err1 = 1'b1;
        if (e0) exp_err0 = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; exu = 0; mem = 0; csr = 0; pc = 0; rd = 0; regs = 0; f3 = 0; regw = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    cm_ready = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if ({cm_valid1, in_ready1, wen1, err1, cm_valid0, in_ready0, wen0, err0} !== 8'b0100_0100)
      $display("FAIL reset_flags: got %b want 01000100",
               {cm_valid1, in_ready1, wen1, err1, cm_valid0, in_ready0, wen0, err0});
    else n_pass++;
    n_total++;
    if (cnt1 !== 64'd0 || data1 !== 32'd0 || addr1 !== 5'd0 || cm_pc1 !== 32'd0)
      $display("FAIL reset_slot: got cnt=%0d data=%h addr=%0d pc=%h want all 0", cnt1, data1, addr1, cm_pc1);
    else n_pass++;
  endtask

  task automatic test_alu();
    apply_reset();
    in_valid = 1; regs = 0; exu = 32'h1234; rd = 5; regw = 1; pc = 32'h100; cm_ready = 1;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if ({cm_valid1, wen1} !== 2'b11 || addr1 !== 5'd5 || data1 !== 32'h1234 || cm_pc1 !== 32'h100)
      $display("FAIL alu_commit: got v=%b wen=%b addr=%0d data=%h pc=%h want v=1 wen=1 addr=5 data=00001234 pc=00000100",
               cm_valid1, wen1, addr1, data1, cm_pc1);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (cnt1 !== 64'd1 || cm_valid1 !== 1'b0)
      $display("FAIL alu_retire: got cnt=%0d v=%b want cnt=1 v=0", cnt1, cm_valid1);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [31:0] want[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    logic [31:0] addr_v[3] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002};
    logic [31:0] mem_v[3] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000};
    logic [2:0]  f3_v[3] = '{3'b000, 3'b100, 3'b001};
    cm_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; regs = 1; regw = 1; rd = 5'(10 + i);
      exu = addr_v[i]; mem = mem_v[i]; f3 = f3_v[i];
      tick();
      #1;
      n_total++;
      if (data1 !== want[i] || cm_valid1 !== 1'b1)
        $display("FAIL load_%0d: got data=%h v=%b want data=%h v=1", i, data1, cm_valid1, want[i]);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_pc_wrap_x0();
    apply_reset();
    cm_ready = 1;
    in_valid = 1; regs = 2; pc = 32'hFFFF_FFFC; rd = 0; regw = 1;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (data1 !== 32'h0 || cm_pc1 !== 32'hFFFF_FFFC || cm_valid1 !== 1'b1)
      $display("FAIL pc_wrap: got data=%h pc=%h v=%b want data=00000000 pc=fffffffc v=1", data1, cm_pc1, cm_valid1);
    else n_pass++;
    n_total++;
    if (wen1 !== 1'b0)
      $display("FAIL x0_wen: got %b want 0", wen1);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (cnt1 !== 64'd1)
      $display("FAIL x0_retire: got %0d want 1", cnt1);
    else n_pass++;
  endtask

  task automatic test_csr();
    cm_ready = 1;
    in_valid = 1; regs = 3; csr = 32'hABCD; rd = 7; regw = 1;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (data1 !== 32'hABCD || wen1 !== 1'b1)
      $display("FAIL csr_sel: got data=%h wen=%b want data=0000abcd wen=1", data1, wen1);
    else n_pass++;
    n_total++;
    if (data0 !== 32'h0 || wen0 !== 1'b0 || err0 !== 1'b1 || err1 !== 1'b0)
      $display("FAIL csr_illegal: got data=%h wen=%b err0=%b err1=%b want data=0 wen=0 err0=1 err1=0",
               data0, wen0, err0, err1);
    else n_pass++;
    tick();
    in_valid = 1; regs = 0; exu = 32'h55; rd = 3; regw = 1;
    tick();
    idle_inputs();
    tick();
    #1;
    n_total++;
    if (err0 !== 1'b1)
      $display("FAIL err_sticky: got %b want 1", err0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    int idx = 0;
    int ncm = 0;
    int nwen = 0;
    apply_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      cm_ready = !(cyc == 1 || cyc == 2);
      in_valid = (idx < 4);
      exu = vals[(idx < 4) ? idx : 0]; regs = 0; rd = 5'(idx + 1); regw = 1;
      #1;
      if (cyc == 1 || cyc == 2) begin
        n_total++;
        if (in_ready1 !== 1'b0 || data1 !== vals[0])
          $display("FAIL b2b_stall_%0d: got rdy=%b data=%h want rdy=0 data=%h", cyc, in_ready1, data1, vals[0]);
        else n_pass++;
      end
      if (wen1 === 1'b1) nwen++;
      if (cm_valid1 === 1'b1 && cm_ready) begin
        n_total++;
        if (ncm >= 4)
          $display("FAIL b2b_extra: got commit %0d want at most 4", ncm + 1);
        else if (data1 !== vals[ncm])
          $display("FAIL b2b_order_%0d: got %h want %h", ncm, data1, vals[ncm]);
        else n_pass++;
        ncm++;
      end
      if (in_valid && in_ready1 === 1'b1) idx++;
      tick();
    end
    idle_inputs();
    #1;
    n_total++;
    if (ncm !== 4 || nwen !== 4 || cnt1 !== 64'd4)
      $display("FAIL b2b_totals: got commits=%0d wen=%0d cnt=%0d want 4/4/4", ncm, nwen, cnt1);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      cm_ready = ($urandom_range(0, 3) != 0);
      exu  = $urandom; mem = $urandom; csr = $urandom; pc = $urandom;
      rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      regs = 2'($urandom); f3 = 3'($urandom); regw = 1'($urandom);
      #1;
      n_total++;
      if ({cm_valid1, cm_valid0, in_ready1, in_ready0, err1, err0} !==
          {q1.size() != 0, q0.size() != 0, (q1.size() == 0) || cm_ready, (q0.size() == 0) || cm_ready,
           exp_err1, exp_err0} || cnt1 !== exp_cnt || cnt0 !== exp_cnt) begin
        $display("FAIL rand_ctrl_%0d: got v=%b rdy=%b err=%b%b cnt=%0d want qsize=%0d err=%b%b cnt=%0d",
                 i, cm_valid1, in_ready1, err1, err0, cnt1, q1.size(), exp_err1, exp_err0, exp_cnt);
        errs++;
      end else n_pass++;
      if (q1.size() != 0) begin
        n_total++;
        if (data1 !== q1[0].data || data0 !== q0[0].data || addr1 !== q1[0].rd || cm_pc1 !== q1[0].pc ||
            wen1 !== (cm_ready && q1[0].wen) || wen0 !== (cm_ready && q0[0].wen)) begin
          $display("FAIL rand_slot_%0d: got d1=%h d0=%h a=%0d pc=%h wen=%b%b want d1=%h d0=%h a=%0d pc=%h wen=%b%b",
                   i, data1, data0, addr1, cm_pc1, wen1, wen0, q1[0].data, q0[0].data, q1[0].rd, q1[0].pc,
                   cm_ready && q1[0].wen, cm_ready && q0[0].wen);
          errs++;
        end else n_pass++;
      end else begin
        n_total++;
        if (wen1 !== 1'b0 || wen0 !== 1'b0) begin
          $display("FAIL rand_idle_wen_%0d: got %b%b want 00", i, wen1, wen0);
          errs++;
        end else n_pass++;
      end
      tick();
      if (errs > 10) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    cm_ready = 1;
    in_valid = 1; regs = 0; exu = 32'h77; rd = 9; regw = 1;
    tick();
    rst = 1; in_valid = 1; exu = 32'h88; rd = 4; cm_ready = 1;
    #1;
    n_total++;
    if (wen1 !== 1'b0 || cm_valid1 !== 1'b0)
      $display("FAIL rst_no_wen: got wen=%b v=%b want 0 0", wen1, cm_valid1);
    else n_pass++;
    tick();
    rst = 0;
    idle_inputs();
    #1;
    n_total++;
    if (cm_valid1 !== 1'b0 || cnt1 !== 64'd0 || err0 !== 1'b0 || err1 !== 1'b0 || wen1 !== 1'b0)
      $display("FAIL rst_inflight: got v=%b cnt=%0d err=%b%b wen=%b want v=0 cnt=0 err=00 wen=0",
               cm_valid1, cnt1, err1, err0, wen1);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (cnt1 !== 64'd0 || cm_valid1 !== 1'b0)
      $display("FAIL rst_after: got cnt=%0d v=%b want 0 0", cnt1, cm_valid1);
    else n_pass++;
  endtask

  initial begin
    rst = 1;
    cm_ready = 0;
    idle_inputs();
    exp_cnt = 0;
    exp_err1 = 0;
    exp_err0 = 0;
    test_reset();
    test_alu();
    test_load();
    test_pc_wrap_x0();
    test_csr();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
